// File: rtl/prod_mem_pkg.sv
// Shared types for the product memory scheduler.
package prod_mem_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_t;

    typedef logic [DW_DEF-1:0] prod_t;

endpackage

// File: rtl/prod_mem_sched_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips only on conflict.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic prio_wr;

    always_comb begin
        gnt_wr = req_wr && (!req_rd || prio_wr);
        gnt_rd = req_rd && (!req_wr || !prio_wr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_wr <= 1'b1;
        end else if (req_wr && req_rd) begin
            prio_wr <= !prio_wr;
        end
    end

endmodule

// File: rtl/prod_mem_sched.sv
// Product memory scheduler: append writes, burst reads, one access per cycle.
// Optional stats counters enabled with `define PROD_MEM_SCHED_STATS_EN.
module prod_mem_sched
    import prod_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_len,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   fill_count,
    output logic          full
`ifdef PROD_MEM_SCHED_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   wr_stall_cnt
`endif
);

    sched_state_t state, state_nxt;

    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_left;
    logic [AW:0]   avail;
    logic [AW:0]   eff_len;
    logic          rd_pend;
    logic          done_pend;
    logic          rd_start;
    logic          wr_elig;
    logic          rd_elig;
    logic          gnt_wr;
    logic          gnt_rd;

    assign full    = (fill_count == (AW+1)'(DEPTH));
    assign wr_elig = rst && wr_valid && !full && !clr;
    assign rd_elig = rst && (state == RUN);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_wr (wr_elig),
        .req_rd (rd_elig),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    // Length is clamped against the pre-clear fill level.
    assign avail    = ({1'b0, rd_base} < fill_count)
                    ? fill_count - {1'b0, rd_base} : '0;
    assign eff_len  = (rd_len < avail) ? rd_len : avail;
    assign rd_start = rst && rd_req && (state == IDLE);

    assign wr_ready  = gnt_wr;
    assign mem_en    = gnt_wr || gnt_rd;
    assign mem_we    = gnt_wr;
    assign mem_addr  = gnt_wr ? fill_count[AW-1:0]
                     : (gnt_rd ? rd_addr : '0);
    assign mem_wdata = gnt_wr ? wr_data : '0;

    assign rd_busy  = rst && (state != IDLE);
    assign rd_valid = rst && rd_pend;
    assign rd_data  = rd_valid ? mem_rdata : '0;
    assign rd_done  = rst && ((state == DRAIN) || done_pend);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_start && (eff_len != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (gnt_rd && (rd_left == (AW+1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_count <= '0;
            rd_addr    <= '0;
            rd_left    <= '0;
            rd_pend    <= 1'b0;
            done_pend  <= 1'b0;
        end else begin
            rd_pend   <= gnt_rd;
            done_pend <= rd_start && (eff_len == '0);
            if (clr) begin
                fill_count <= '0;
            end else if (gnt_wr) begin
                fill_count <= fill_count + 1'b1;
            end
            if (rd_start) begin
                rd_addr <= rd_base;
                rd_left <= eff_len;
            end else if (gnt_rd) begin
                rd_addr <= rd_addr + 1'b1;
                rd_left <= rd_left - 1'b1;
            end
        end
    end

`ifdef PROD_MEM_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            conflict_cnt <= '0;
            wr_stall_cnt <= '0;
        end else begin
            if (wr_elig && rd_elig && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prod_mem_sched.sv
// Scoreboard bench for prod_mem_sched with a behavioural memory macro.
module tb_prod_mem_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        rd_req = 1'b0;
    logic [5:0]  rd_base = '0;
    logic [6:0]  rd_len = '0;
    logic        rd_busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [6:0]  fill_count;
    logic        full;
`ifdef PROD_MEM_SCHED_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] wr_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [38:0] exp_acc[$];
    logic [33:0] exp_rd[$];
    logic [31:0] mem[64];

    prod_mem_sched dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .rd_busy    (rd_busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fill_count (fill_count),
        .full       (full)
`ifdef PROD_MEM_SCHED_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_unexp(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, got);
    endtask

    // Monitor: every memory access and read-side event is popped and compared.
    always @(negedge clk) begin
        if (mem_en) begin
            if (exp_acc.size() == 0)
                fail_unexp("mem_access", 64'({mem_we, mem_addr, mem_wdata}));
            else
                check("mem_access", 64'({mem_we, mem_addr, mem_wdata}),
                      64'(exp_acc.pop_front()));
        end
        if (rd_valid || rd_done) begin
            if (exp_rd.size() == 0)
                fail_unexp("rd_event", 64'({rd_valid, rd_done, rd_data}));
            else
                check("rd_event", 64'({rd_valid, rd_done, rd_data}),
                      64'(exp_rd.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_valid = 1'b0;
        rd_req = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic fill(input int n, input int base_val);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data = 32'(base_val + i);
            exp_acc.push_back({1'b1, 6'(i), 32'(base_val + i)});
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (rd_busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(rd_busy), 64'(0));
    endtask

    initial begin
        // Write-only fill to full, then clear while full
        do_reset();
        check("reset_fill", 64'(fill_count), 64'(0));
        check("reset_full", 64'(full), 64'(0));
        check("reset_busy", 64'(rd_busy), 64'(0));
        check("reset_mem_en", 64'(mem_en), 64'(0));
        check("reset_rd_valid", 64'(rd_valid), 64'(0));
        fill(64, 1);
        check("full_fill", 64'(fill_count), 64'(64));
        check("full_flag", 64'(full), 64'(1));
        wr_valid = 1'b1;
        wr_data = 32'd65;
        #1;
        check("full_wr_ready", 64'(wr_ready), 64'(0));
        tick();
        check("full_hold", 64'(fill_count), 64'(64));
        clr = 1'b1;
        #1;
        check("clr_blocks_wr", 64'(wr_ready), 64'(0));
        tick();
        clr = 1'b0;
        wr_data = 32'hAA;
        #1;
        check("clr_fill", 64'(fill_count), 64'(0));
        check("clr_wr_ready", 64'(wr_ready), 64'(1));
        exp_acc.push_back({1'b1, 6'd0, 32'hAA});
        tick();
        wr_valid = 1'b0;
        check("clr_next_fill", 64'(fill_count), 64'(1));
        check("clr_full", 64'(full), 64'(0));

        // Burst read base 2 len 4 of 10 entries
        do_reset();
        fill(10, 100);
        for (int j = 0; j < 4; j++) begin
            exp_acc.push_back({1'b0, 6'(2 + j), 32'd0});
            exp_rd.push_back({1'b1, (j == 3), 32'(102 + j)});
        end
        rd_base = 6'd2;
        rd_len = 7'd4;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("burst_busy", 64'(rd_busy), 64'(1));
        wait_idle("burst_end");

        // Clamp: 5 entries, base 3 len 10 gives two beats
        do_reset();
        fill(5, 200);
        exp_acc.push_back({1'b0, 6'd3, 32'd0});
        exp_acc.push_back({1'b0, 6'd4, 32'd0});
        exp_rd.push_back({1'b1, 1'b0, 32'd203});
        exp_rd.push_back({1'b1, 1'b1, 32'd204});
        rd_base = 6'd3;
        rd_len = 7'd10;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_idle("clamp_end");
        exp_rd.push_back({1'b1 ^ 1'b1, 1'b1, 32'd0});
        rd_base = 6'd7;
        rd_len = 7'd4;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("oob_not_busy", 64'(rd_busy), 64'(0));
        tick();
        exp_rd.push_back({1'b0, 1'b1, 32'd0});
        rd_base = 6'd0;
        rd_len = 7'd0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("zero_len_not_busy", 64'(rd_busy), 64'(0));
        tick();

        // Contention: alternating grants starting with write
        do_reset();
        fill(8, 300);
        rd_base = 6'd0;
        rd_len = 7'd8;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_acc.push_back({1'b1, 6'(8 + k), 32'(400 + k)});
            exp_acc.push_back({1'b0, 6'(k), 32'd0});
            exp_rd.push_back({1'b1, (k == 7), 32'(300 + k)});
        end
        wr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            wr_data = 32'(400 + c / 2);
            tick();
        end
        wr_valid = 1'b0;
        check("cont_drain_busy", 64'(rd_busy), 64'(1));
        tick();
        check("cont_fill", 64'(fill_count), 64'(16));
        check("cont_idle", 64'(rd_busy), 64'(0));

        // Reset two cycles into a len 6 burst
        do_reset();
        fill(8, 500);
        exp_acc.push_back({1'b0, 6'd0, 32'd0});
        exp_acc.push_back({1'b0, 6'd1, 32'd0});
        exp_rd.push_back({1'b1, 1'b0, 32'd500});
        rd_base = 6'd0;
        rd_len = 7'd6;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("rst_mid_fill", 64'(fill_count), 64'(0));
        check("rst_mid_busy", 64'(rd_busy), 64'(0));

        check("acc_queue_empty", 64'(exp_acc.size()), 64'(0));
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
